uart_apb_stream_bridge: RTL

//  APB master that drives the UART's APB slave port from byte streams. Accepts TX bytes on a

---
 rtl/uart_bridge_pkg.sv | 27 ++
 rtl/uart_apb_stream_bridge.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared state encoding, strobe constants and default register map for the UART APB bridge.
// The RD_* states only exist when UART_RX_DRAIN_EN is defined.
package uart_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    WR_SETUP  = 3'd3,
    WR_ACCESS = 3'd4
`ifdef UART_RX_DRAIN_EN
    ,
    RD_SETUP  = 3'd5,
    RD_ACCESS = 3'd6
`endif
  } state_t;

  localparam logic [3:0]  PSTRB_WR        = 4'b0001;
  localparam logic [3:0]  PSTRB_RD        = 4'b0000;
  localparam logic [31:0] DEF_ADDR_DATA   = 32'h0000_0000;
  localparam logic [31:0] DEF_ADDR_STATUS = 32'h0000_0008;

  function automatic logic [31:0] byte_word(input logic [7:0] b);
    return {24'h0, b};
  endfunction

endpackage

// File: rtl/uart_apb_stream_bridge.sv
// APB master feeding uart_top: polls status, writes each held TX byte once the TX FIFO has room.
// Define UART_RX_DRAIN_EN to also poll RXNE and drain RX bytes onto the m_* stream.
module uart_apb_stream_bridge
  import uart_bridge_pkg::*;
#(
  parameter logic [31:0] ADDR_DATA   = DEF_ADDR_DATA,
  parameter logic [31:0] ADDR_STATUS = DEF_ADDR_STATUS,
  parameter int          TXNF_BIT    = 0,
  parameter int          RXNE_BIT    = 3,
  parameter int          TO_CYCLES   = 16
) (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [7:0]  m_data,
  input  logic        m_ready,
  output logic [31:0] paddr,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  output logic        err_sticky
);

  localparam int CW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;

  state_t          state;
  logic            held;
  logic [7:0]      hold_byte;
  logic [CW-1:0]   to_cnt;
  logic            timeout, done, fail, ok, txnf, poll_req;

  assign s_ready = ~held;
  // penable is high exactly in the ACCESS states, so it doubles as the "in access" flag
  assign timeout = penable && !pready && (to_cnt == CW'(TO_CYCLES - 1));
  assign done    = pready || timeout;
  assign fail    = (pready && pslverr) || timeout;
  assign ok      = pready && !pslverr;
  assign txnf    = prdata[TXNF_BIT];

`ifdef UART_RX_DRAIN_EN
  logic       rx_vld;
  logic [7:0] rx_dat;
  logic       rxne;
  logic       unused_ok;
  assign m_valid   = rx_vld;
  assign m_data    = rx_dat;
  assign rxne      = prdata[RXNE_BIT];
  assign poll_req  = held || !rx_vld;
  assign unused_ok = ^prdata[31:8];
`else
  logic unused_ok;
  assign m_valid   = 1'b0;
  assign m_data    = 8'h0;
  assign poll_req  = held;
  assign unused_ok = ^{prdata, prdata[RXNE_BIT], m_ready};
`endif

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state      <= IDLE;
      held       <= 1'b0;
      hold_byte  <= 8'h0;
      to_cnt     <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      pstrb      <= '0;
      err_sticky <= 1'b0;
`ifdef UART_RX_DRAIN_EN
      rx_vld     <= 1'b0;
      rx_dat     <= 8'h0;
`endif
    end else begin
      if (s_valid && !held) begin
        held      <= 1'b1;
        hold_byte <= s_data;
      end
      if (penable && !pready) to_cnt <= to_cnt + CW'(1);
      if (penable && fail) err_sticky <= 1'b1;
`ifdef UART_RX_DRAIN_EN
      if (rx_vld && m_ready) rx_vld <= 1'b0;
`endif
      case (state)
        IDLE: if (poll_req) begin
          psel   <= 1'b1;
          pwrite <= 1'b0;
          paddr  <= ADDR_STATUS;
          pwdata <= '0;
          pstrb  <= PSTRB_RD;
          state  <= ST_SETUP;
        end
        ST_SETUP: begin
          penable <= 1'b1;
          to_cnt  <= '0;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: if (done) begin
          penable <= 1'b0;
          // TX has priority over RX when both FIFOs are ready
          if (ok && held && txnf) begin
            pwrite <= 1'b1;
            paddr  <= ADDR_DATA;
            pwdata <= byte_word(hold_byte);
            pstrb  <= PSTRB_WR;
            state  <= WR_SETUP;
          end
`ifdef UART_RX_DRAIN_EN
          else if (ok && rxne && !rx_vld) begin
            paddr <= ADDR_DATA;
            state <= RD_SETUP;
          end
`endif
          else begin
            psel  <= 1'b0;
            state <= IDLE;
          end
        end
        WR_SETUP: begin
          penable <= 1'b1;
          to_cnt  <= '0;
          state   <= WR_ACCESS;
        end
        WR_ACCESS: if (done) begin
          psel    <= 1'b0;
          penable <= 1'b0;
          held    <= 1'b0;
          state   <= IDLE;
        end
`ifdef UART_RX_DRAIN_EN
        RD_SETUP: begin
          penable <= 1'b1;
          to_cnt  <= '0;
          state   <= RD_ACCESS;
        end
        RD_ACCESS: if (done) begin
          psel    <= 1'b0;
          penable <= 1'b0;
          if (ok) begin
            rx_vld <= 1'b1;
            rx_dat <= prdata[7:0];
          end
          state <= IDLE;
        end
`endif
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
